ps2_host_write: RTL and testbench

- PS/2 host-to-device transmitter; the write counterpart of the mouse packet reader.
- Sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the mouse over the open-drain PS2C/PS2D lines and checks the device ACK.
- Sits beside the reader under the top-level controller. The top level must not enable the reader while busy=1.
- Top level owns the tri-state pads: pad driven 0 when *_oe=1, else high-Z with pull-up.

---
 rtl/ps2_host_write.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_host_write.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_write.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked frame, ACK check.
// Optional PS2C glitch filter enabled by defining PS2_TX_FILTER_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | lines released, waiting for start
// INHIBIT   | PS2C held low for INHIBIT_CYCLES
// REQ       | PS2C and PS2D held low (start bit) for REQ_CYCLES
// SEND      | device clocks out 8 data bits, parity and stop
// ACK       | waiting for 11th falling edge to sample the device ACK
// WAIT_IDLE | waiting for both lines high before reporting done
module ps2_host_write #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned REQ_CYCLES     = 250,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       qzt_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] errcode
);

  localparam int unsigned MAX_A = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int unsigned MAX_L = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned TW    = $clog2(MAX_L + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [8:0]    frame, frame_n;
  logic          d_low, d_low_n;
  logic          done_r, done_n;
  logic          err_r, err_n;
  logic [7:0]    errcode_r, errcode_n;

  logic c_s1, c_s2, d_s1, d_s2;
  logic c_lvl, c_lvl_q, c_fall;

  // Idle lines are high, so synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2c_in;
      c_s2 <= c_s1;
      d_s1 <= ps2d_in;
      d_s2 <= d_s1;
    end
  end

`ifdef PS2_TX_FILTER_EN
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);

  logic [FW-1:0] flt_cnt;
  logic          c_flt;

  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      c_flt   <= 1'b1;
      flt_cnt <= '0;
    end else if (c_s2 == c_flt) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      c_flt   <= c_s2;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + FW'(1);
    end
  end

  assign c_lvl = c_flt;
`else
  logic unused_filter_len;
  assign unused_filter_len = (FILTER_LEN == 0);
  assign c_lvl = c_s2;
`endif

  always_ff @(posedge qzt_clk) begin
    if (rst) c_lvl_q <= 1'b1;
    else     c_lvl_q <= c_lvl;
  end

  assign c_fall = c_lvl_q & ~c_lvl;

  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      bit_cnt   <= '0;
      frame     <= '0;
      d_low     <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      errcode_r <= '0;
    end else begin
      state     <= state_n;
      tmr       <= tmr_n;
      bit_cnt   <= bit_cnt_n;
      frame     <= frame_n;
      d_low     <= d_low_n;
      done_r    <= done_n;
      err_r     <= err_n;
      errcode_r <= errcode_n;
    end
  end

  always_comb begin
    state_n   = state;
    tmr_n     = tmr;
    bit_cnt_n = bit_cnt;
    frame_n   = frame;
    d_low_n   = d_low;
    done_n    = 1'b0;
    err_n     = err_r;
    errcode_n = errcode_r;
    case (state)
      S_IDLE: begin
        // A start coinciding with the done pulse belongs to the old transfer.
        if (start && !done_r) begin
          frame_n   = {~^tx_byte, tx_byte};
          bit_cnt_n = '0;
          err_n     = 1'b0;
          errcode_n = 8'd0;
          tmr_n     = TW'(INHIBIT_CYCLES - 1);
          state_n   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (tmr == '0) begin
          tmr_n   = TW'(REQ_CYCLES - 1);
          state_n = S_REQ;
        end else begin
          tmr_n = tmr - TW'(1);
        end
      end
      S_REQ: begin
        if (tmr == '0) begin
          tmr_n   = TW'(TIMEOUT_CYCLES - 1);
          d_low_n = 1'b1;
          state_n = S_SEND;
        end else begin
          tmr_n = tmr - TW'(1);
        end
      end
      S_SEND, S_ACK, S_WAIT_IDLE: begin
        if (tmr == '0) begin
          d_low_n   = 1'b0;
          err_n     = 1'b1;
          errcode_n = 8'd1;
          done_n    = 1'b1;
          state_n   = S_IDLE;
        end else begin
          tmr_n = tmr - TW'(1);
          if (state == S_SEND && c_fall) begin
            tmr_n = TW'(TIMEOUT_CYCLES - 1);
            if (bit_cnt == 4'd9) begin
              d_low_n = 1'b0;
              state_n = S_ACK;
            end else begin
              d_low_n   = ~frame[bit_cnt];
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end else if (state == S_ACK && c_fall) begin
            tmr_n = TW'(TIMEOUT_CYCLES - 1);
            if (d_s2) begin
              err_n     = 1'b1;
              errcode_n = 8'd2;
            end
            state_n = S_WAIT_IDLE;
          end else if (state == S_WAIT_IDLE && c_lvl && d_s2) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign ps2c_oe = (state == S_INHIBIT) || (state == S_REQ);
  assign ps2d_oe = (state == S_REQ) || ((state == S_SEND) && d_low);
  assign busy    = (state != S_IDLE);
  assign done    = done_r;
  assign err     = err_r;
  assign errcode = errcode_r;

endmodule

// File: tb/tb_ps2_host_write.sv
// Bench for ps2_host_write: open-drain PS/2 device model, frame/ACK/timeout/reset/glitch checks.
module tb_ps2_host_write;

  localparam int INH = 50;
  localparam int RQ  = 10;
  localparam int TO  = 400;
  localparam int FL  = 8;
  localparam int H   = 20;

  logic       qzt_clk = 1'b0;
  logic       rst, start;
  logic [7:0] tx_byte;
  logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe, busy, done, err;
  logic [7:0] errcode;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;

  assign ps2c_in = dev_c & ~ps2c_oe;
  assign ps2d_in = dev_d & ~ps2d_oe;

  always #5 qzt_clk = ~qzt_clk;

  ps2_host_write #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (RQ),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FL)
  ) dut (
    .qzt_clk(qzt_clk),
    .rst    (rst),
    .start  (start),
    .tx_byte(tx_byte),
    .ps2c_in(ps2c_in),
    .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .errcode(errcode)
  );

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int c_oe_cnt = 0;
  int cd_oe_cnt = 0;

  always @(posedge qzt_clk) begin
    if (done) done_cnt++;
    if (ps2c_oe) c_oe_cnt++;
    if (ps2c_oe && ps2d_oe) cd_oe_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
  endtask

  task automatic chk_ne(input string nm, input logic [31:0] act, input logic [31:0] bad_v);
    n_total++;
    if (act !== bad_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected anything else", nm, act);
  endtask

  // Received frame as the device sees it: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'((b >> i) & 8'd1);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  task automatic dev_xfer(input bit give_ack, input int glitch_k,
                          output logic [10:0] rx, output bit ok);
    int n = 0;
    ok = 1'b1;
    rx = '0;
    while (ps2c_in !== 1'b0 && n < 200) begin @(negedge qzt_clk); n++; end
    while (!(ps2c_in === 1'b1 && ps2d_in === 1'b0) && n < 200) begin @(negedge qzt_clk); n++; end
    if (n >= 200) begin
      ok = 1'b0;
      return;
    end
    repeat (30) @(negedge qzt_clk);
    rx[0] = ps2d_in;
    for (int k = 1; k <= 11; k++) begin
      dev_c = 1'b0;
      repeat (H) @(negedge qzt_clk);
      dev_c = 1'b1;
      if (k <= 10) rx[k] = ps2d_in;
      if (k == 11) dev_d = 1'b1;
      if (k == glitch_k) begin
        repeat (6) @(negedge qzt_clk);
        dev_c = 1'b0;
        repeat (3) @(negedge qzt_clk);
        dev_c = 1'b1;
        repeat (H - 9) @(negedge qzt_clk);
      end else if (k == 10 && give_ack) begin
        repeat (H / 2) @(negedge qzt_clk);
        dev_d = 1'b0;
        repeat (H - H / 2) @(negedge qzt_clk);
      end else begin
        repeat (H) @(negedge qzt_clk);
      end
    end
  endtask

  task automatic run_xfer(input logic [7:0] b, input bit ack, input int glitch_k,
                          input bit mid_start, input bit start_on_done,
                          output logic [10:0] rx, output bit ok);
    int n;
    fork
      dev_xfer(ack, glitch_k, rx, ok);
      begin
        @(negedge qzt_clk);
        tx_byte = b;
        start   = 1'b1;
        @(negedge qzt_clk);
        start = 1'b0;
        if (mid_start) begin
          repeat (150) @(negedge qzt_clk);
          tx_byte = 8'h00;
          start   = 1'b1;
          @(negedge qzt_clk);
          start   = 1'b0;
          tx_byte = b;
        end
        if (start_on_done) begin
          n = 0;
          while (!done && n < 2000) begin @(negedge qzt_clk); n++; end
          chk("done_seen", 32'(done), 32'd1);
          start   = 1'b1;
          tx_byte = 8'h55;
          @(negedge qzt_clk);
          start = 1'b0;
          chk("start_with_done_ignored", 32'(busy), 32'd0);
        end
      end
    join
    n = 0;
    while (busy && n < 500) begin @(negedge qzt_clk); n++; end
    chk("busy_released", 32'(busy), 32'd0);
    repeat (10) @(negedge qzt_clk);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         ack;
    bit         par;
    bit         e;
    logic [7:0] ec;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vt[5];
    logic [10:0] rx;
    bit          ok;
    int          base_done, base_c, base_cd, n;
    logic [7:0]  rb;
    bit          rack;

    vt[0] = '{8'hF4, 1'b1, 1'b0, 1'b0, 8'd0};
    vt[1] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'd0};
    vt[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'd0};
    vt[3] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'd2};
    vt[4] = '{8'h01, 1'b1, 1'b0, 1'b0, 8'd0};

    rst = 1'b1;
    start = 1'b0;
    tx_byte = 8'h00;
    repeat (3) @(negedge qzt_clk);
    chk("rst_ps2c_oe", 32'(ps2c_oe), 32'd0);
    chk("rst_ps2d_oe", 32'(ps2d_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_errcode", 32'(errcode), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge qzt_clk);

    for (int i = 0; i < 5; i++) begin
      base_done = done_cnt;
      base_c    = c_oe_cnt;
      base_cd   = cd_oe_cnt;
      run_xfer(vt[i].b, vt[i].ack, 0, 1'b0, (i == 0), rx, ok);
      chk("tbl_dev_req", 32'(ok), 32'd1);
      chk("tbl_frame", 32'(rx), 32'(model_frame(vt[i].b)));
      chk("tbl_parity", 32'(rx[9]), 32'(vt[i].par));
      chk("tbl_err", 32'(err), 32'(vt[i].e));
      chk("tbl_errcode", 32'(errcode), 32'(vt[i].ec));
      chk("tbl_done_pulses", 32'(done_cnt - base_done), 32'd1);
      chk("tbl_ps2c_low_cycles", 32'(c_oe_cnt - base_c), 32'(INH + RQ));
      chk("tbl_req_overlap_cycles", 32'(cd_oe_cnt - base_cd), 32'(RQ));
    end

    for (int i = 0; i < 8; i++) begin
      rb   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      base_done = done_cnt;
      run_xfer(rb, rack, 0, 1'b0, 1'b0, rx, ok);
      chk("rnd_frame", 32'(rx), 32'(model_frame(rb)));
      chk("rnd_err", 32'(err), rack ? 32'd0 : 32'd1);
      chk("rnd_errcode", 32'(errcode), rack ? 32'd0 : 32'd2);
      chk("rnd_done_pulses", 32'(done_cnt - base_done), 32'd1);
    end

    // Device never clocks: timeout measured from the release of PS2C.
    base_done = done_cnt;
    @(negedge qzt_clk);
    tx_byte = 8'h3C;
    start   = 1'b1;
    @(negedge qzt_clk);
    start = 1'b0;
    n = 0;
    while (ps2c_oe && n < 1000) begin @(negedge qzt_clk); n++; end
    chk("to_req_released", 32'(ps2c_oe), 32'd0);
    n = 0;
    while (!done && n < TO + 50) begin @(negedge qzt_clk); n++; end
    chk("to_cycles", 32'(n), 32'(TO));
    chk("to_err", 32'(err), 32'd1);
    chk("to_errcode", 32'(errcode), 32'd1);
    chk("to_ps2c_oe", 32'(ps2c_oe), 32'd0);
    chk("to_ps2d_oe", 32'(ps2d_oe), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge qzt_clk);
    chk("to_err_held", 32'(err), 32'd1);
    chk("to_errcode_held", 32'(errcode), 32'd1);
    chk("to_done_pulses", 32'(done_cnt - base_done), 32'd1);
    tx_byte = 8'h3C;
    start   = 1'b1;
    @(negedge qzt_clk);
    start = 1'b0;
    chk("err_cleared_on_start", 32'(err), 32'd0);
    chk("errcode_cleared_on_start", 32'(errcode), 32'd0);
    n = 0;
    while (busy && n < 1000) begin @(negedge qzt_clk); n++; end
    chk("to2_errcode", 32'(errcode), 32'd1);
    repeat (10) @(negedge qzt_clk);

    // start with a different byte in the middle of SEND must not disturb the frame.
    base_done = done_cnt;
    run_xfer(8'hF4, 1'b1, 0, 1'b1, 1'b0, rx, ok);
    chk("midstart_frame", 32'(rx), 32'(model_frame(8'hF4)));
    chk("midstart_err", 32'(err), 32'd0);
    chk("midstart_done_pulses", 32'(done_cnt - base_done), 32'd1);

    // Reset in the middle of SEND: lines released next cycle, no done ever.
    base_done = done_cnt;
    fork
      dev_xfer(1'b1, 0, rx, ok);
      begin
        @(negedge qzt_clk);
        tx_byte = 8'hF4;
        start   = 1'b1;
        @(negedge qzt_clk);
        start = 1'b0;
        repeat (150) @(negedge qzt_clk);
        rst = 1'b1;
        @(negedge qzt_clk);
        rst = 1'b0;
        chk("midrst_ps2c_oe", 32'(ps2c_oe), 32'd0);
        chk("midrst_ps2d_oe", 32'(ps2d_oe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
      end
    join
    repeat (50) @(negedge qzt_clk);
    chk("midrst_no_done", 32'(done_cnt - base_done), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    // Short PS2C glitch between valid clocks.
    run_xfer(8'hF4, 1'b1, 3, 1'b0, 1'b0, rx, ok);
`ifdef PS2_TX_FILTER_EN
    chk("glitch_filtered_frame", 32'(rx), 32'(model_frame(8'hF4)));
    chk("glitch_filtered_err", 32'(err), 32'd0);
`else
    chk_ne("glitch_unfiltered_frame", 32'(rx), 32'(model_frame(8'hF4)));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
